// File: rtl/ipv4_arp_pkg.sv
// -----------------------------------------------------------------------------
// ipv4_arp_pkg
// Shared definitions for the IPv4 next-hop to Ethernet address lookup table:
// FSM state encoding and the default table geometry used by the ipv4 LUT
// blocks. No ports; imported with `import ipv4_arp_pkg::*;`.
// -----------------------------------------------------------------------------
package ipv4_arp_pkg;

    localparam int ARP_ROWS_DEF      = 32;
    localparam int ARP_MAC_WIDTH_DEF = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } arp_state_e;

    // Absolute row index of entry `off` inside chunk `k`.
    function automatic int chunk_row(input int k, input int off, input int chunk);
        return (k * chunk) + off;
    endfunction

endpackage

// File: rtl/ipv4_arp_chunk_match.sv
// -----------------------------------------------------------------------------
// ipv4_arp_chunk_match
// Combinational comparison of one chunk of table entries against the lookup
// address. An entry matches only when its valid bit is set and its address
// equals daddr_i; the lowest matching offset is reported.
// Ports:
//   daddr_i  - address being looked up
//   addr_i   - CHUNK stored IPv4 addresses
//   valid_i  - CHUNK entry valid bits
//   hit_o    - at least one entry matched
//   off_o    - offset of the lowest-index match (0 when no hit)
// -----------------------------------------------------------------------------
module ipv4_arp_chunk_match #(
    parameter int CHUNK    = 8,
    parameter int OFF_BITS = 3
) (
    input  logic [31:0]            daddr_i,
    input  logic [CHUNK-1:0][31:0] addr_i,
    input  logic [CHUNK-1:0]       valid_i,
    output logic                   hit_o,
    output logic [OFF_BITS-1:0]    off_o
);

    logic [CHUNK-1:0] match_s;

    // Per-entry match vector.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            match_s[i] = valid_i[i] && (addr_i[i] == daddr_i);
        end
    end

    // Walk from the top down so the lowest matching offset is written last and wins.
    always_comb begin
        off_o = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            off_o = match_s[i] ? OFF_BITS'(i) : off_o;
        end
    end

    assign hit_o = |match_s;

endmodule

// File: rtl/ipv4_arp_cam.sv
// -----------------------------------------------------------------------------
// ipv4_arp_cam
// IPv4 next-hop to Ethernet address lookup table. Lookups scan the table one
// chunk per cycle and stop at the first hit; results are held until accepted.
// A management port reads/writes single rows and a bulk clear invalidates
// every row. Hit/miss counters saturate at all-ones.
// Ports:
//   clk, resetn                         - clock, synchronous active-low reset
//   i_lkup_daddr/valid, o_lkup_ready    - lookup request handshake
//   o_res_valid/i_res_ready             - result handshake
//   o_res_found/eth_addr/row            - registered lookup result
//   i_rd_req/addr, o_rd_ack, o_rd_*     - management read, registered data
//   i_wr_req/addr/data, o_wr_ack        - management write (stalls in SCAN/CLEAR)
//   i_clear, o_clear_busy               - bulk invalidate
//   o_hit_cnt, o_miss_cnt               - saturating statistics
// -----------------------------------------------------------------------------
module ipv4_arp_cam
    import ipv4_arp_pkg::*;
#(
    parameter int ROWS      = ARP_ROWS_DEF,
    parameter int ROW_BITS  = 5,
    parameter int CHUNK     = 8,
    parameter int MAC_WIDTH = ARP_MAC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          i_lkup_daddr,
    input  logic                 i_lkup_valid,
    output logic                 o_lkup_ready,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_res_found,
    output logic [MAC_WIDTH-1:0] o_res_eth_addr,
    output logic [ROW_BITS-1:0]  o_res_row,
    input  logic                 i_rd_req,
    input  logic [ROW_BITS-1:0]  i_rd_addr,
    output logic                 o_rd_ack,
    output logic [31:0]          o_rd_ipv4_addr,
    output logic [MAC_WIDTH-1:0] o_rd_eth_addr,
    output logic                 o_rd_entry_valid,
    input  logic                 i_wr_req,
    input  logic [ROW_BITS-1:0]  i_wr_addr,
    input  logic [31:0]          i_wr_ipv4_addr,
    input  logic [63:0]          i_wr_eth_addr,
    input  logic                 i_wr_entry_valid,
    output logic                 o_wr_ack,
    input  logic                 i_clear,
    output logic                 o_clear_busy,
    output logic [31:0]          o_hit_cnt,
    output logic [31:0]          o_miss_cnt
);

    localparam int K_ROWS   = ROWS / CHUNK;
    localparam int K_BITS   = (K_ROWS > 1) ? $clog2(K_ROWS) : 1;
    localparam int OFF_BITS = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam logic [K_BITS-1:0] K_LAST = K_BITS'(K_ROWS - 1);

    arp_state_e            state_q, state_d;
    logic [K_BITS-1:0]     k_q, k_d;
    logic [31:0]           daddr_q, daddr_d;
    logic                  res_found_q, res_found_d;
    logic [MAC_WIDTH-1:0]  res_eth_q, res_eth_d;
    logic [ROW_BITS-1:0]   res_row_q, res_row_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic                  clear_pend_q, clear_pend_d;

    logic [31:0]           ip_mem_q  [ROWS];
    logic [MAC_WIDTH-1:0]  mac_mem_q [ROWS];
    logic [ROWS-1:0]       valid_q;

    logic                  rd_ack_q;
    logic [31:0]           rd_ip_q;
    logic [MAC_WIDTH-1:0]  rd_eth_q;
    logic                  rd_valid_q;
    logic                  wr_ack_q;

    logic [CHUNK-1:0][31:0] chunk_addr_s;
    logic [CHUNK-1:0]       chunk_valid_s;
    logic                   chunk_hit_s;
    logic [OFF_BITS-1:0]    chunk_off_s;
    logic [ROW_BITS-1:0]    hit_row_s;
    logic                   wr_accept_s;
    logic                   clr_chunk_s;
    logic [ROWS-1:0]        clr_mask_s;

    if (MAC_WIDTH < 64) begin : g_wr_eth_unused
        logic unused_wr_eth_s;
        assign unused_wr_eth_s = ^i_wr_eth_addr[63:MAC_WIDTH];
    end

    // Writes only land in IDLE/DONE so a scan never sees a half-updated table.
    // A concurrent read goes first; the held ack blocks a second write of the same request.
    assign wr_accept_s = i_wr_req && !i_rd_req && !wr_ack_q &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign clr_chunk_s = (state_q == ST_CLEAR);
    assign hit_row_s   = ROW_BITS'(chunk_row(int'(k_q), int'(chunk_off_s), CHUNK));

    // Gather the entries of the chunk currently being scanned.
    always_comb begin
        chunk_addr_s  = '0;
        chunk_valid_s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_addr_s[i]  = ip_mem_q[ROW_BITS'(chunk_row(int'(k_q), i, CHUNK))];
            chunk_valid_s[i] = valid_q[ROW_BITS'(chunk_row(int'(k_q), i, CHUNK))];
        end
    end

    ipv4_arp_chunk_match #(
        .CHUNK    (CHUNK),
        .OFF_BITS (OFF_BITS)
    ) u_match (
        .daddr_i (daddr_q),
        .addr_i  (chunk_addr_s),
        .valid_i (chunk_valid_s),
        .hit_o   (chunk_hit_s),
        .off_o   (chunk_off_s)
    );

    // Rows of chunk k to invalidate during a bulk clear.
    always_comb begin
        clr_mask_s = '0;
        for (int i = 0; i < ROWS; i++) begin
            clr_mask_s[i] = clr_chunk_s && (K_BITS'(i / CHUNK) == k_q);
        end
    end

    // FSM next state, result capture and counter update.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        daddr_d      = daddr_q;
        res_found_d  = res_found_q;
        res_eth_d    = res_eth_q;
        res_row_d    = res_row_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        // A clear arriving outside IDLE is remembered until the FSM gets back there.
        clear_pend_d = clear_pend_q | (i_clear && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (i_clear || clear_pend_q) begin
                    state_d      = ST_CLEAR;
                    k_d          = '0;
                    clear_pend_d = 1'b0;
                end else if (i_lkup_valid) begin
                    state_d = ST_SCAN;
                    k_d     = '0;
                    daddr_d = i_lkup_daddr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (chunk_hit_s) begin
                    state_d     = ST_DONE;
                    res_found_d = 1'b1;
                    res_eth_d   = mac_mem_q[hit_row_s];
                    res_row_d   = hit_row_s;
                end else if (k_q == K_LAST) begin
                    state_d     = ST_DONE;
                    res_found_d = 1'b0;
                    res_eth_d   = '0;
                    res_row_d   = '0;
                end else begin
                    k_d = k_q + K_BITS'(1);
                end
            end
            ST_DONE: begin
                if (i_res_ready) begin
                    state_d = ST_IDLE;
                    if (res_found_q) begin
                        hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
                    end else begin
                        miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CLEAR: begin
                if (k_q == K_LAST) begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + K_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // FSM, result and counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            daddr_q      <= 32'd0;
            res_found_q  <= 1'b0;
            res_eth_q    <= '0;
            res_row_q    <= '0;
            hit_cnt_q    <= 32'd0;
            miss_cnt_q   <= 32'd0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            daddr_q      <= daddr_d;
            res_found_q  <= res_found_d;
            res_eth_q    <= res_eth_d;
            res_row_q    <= res_row_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    // Address/MAC storage; deliberately not reset, the valid bits gate it.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            ip_mem_q[i_wr_addr]  <= i_wr_ipv4_addr;
            mac_mem_q[i_wr_addr] <= i_wr_eth_addr[MAC_WIDTH-1:0];
        end
    end

    // Entry valid bits: bulk clear by chunk, or single-row write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (clr_chunk_s) begin
            valid_q <= valid_q & ~clr_mask_s;
        end else if (wr_accept_s) begin
            valid_q[i_wr_addr] <= i_wr_entry_valid;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Management read data and the read/write acknowledge pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ack_q   <= 1'b0;
            rd_ip_q    <= 32'd0;
            rd_eth_q   <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            rd_ack_q <= i_rd_req;
            wr_ack_q <= wr_accept_s;
            if (i_rd_req) begin
                rd_ip_q    <= ip_mem_q[i_rd_addr];
                rd_eth_q   <= mac_mem_q[i_rd_addr];
                rd_valid_q <= valid_q[i_rd_addr];
            end
        end
    end

    assign o_lkup_ready     = (state_q == ST_IDLE) && !i_clear && !clear_pend_q;
    assign o_res_valid      = (state_q == ST_DONE);
    assign o_res_found      = res_found_q;
    assign o_res_eth_addr   = res_eth_q;
    assign o_res_row        = res_row_q;
    assign o_rd_ack         = rd_ack_q;
    assign o_rd_ipv4_addr   = rd_ip_q;
    assign o_rd_eth_addr    = rd_eth_q;
    assign o_rd_entry_valid = rd_valid_q;
    assign o_wr_ack         = wr_ack_q;
    assign o_clear_busy     = (state_q == ST_CLEAR);
    assign o_hit_cnt        = hit_cnt_q;
    assign o_miss_cnt       = miss_cnt_q;

endmodule
